// File: rtl/set_assoc_icache_fetch_pkg.sv
// Shared types and helpers for the set-associative fetch icache.
// Imported by the top and the victim picker.
package set_assoc_icache_fetch_pkg;

    typedef enum logic [1:0] {
        ST_DEFAULT    = 2'd0,
        ST_REFILL     = 2'd1,
        ST_INVALIDATE = 2'd2
    } icache_state_e;

    // Way index width; a direct-mapped cache still needs one bit.
    function automatic int unsigned way_idx_width(
        input int unsigned ways
    );
        return (ways > 1) ? $clog2(ways) : 1;
    endfunction

endpackage

// File: rtl/icache_victim_picker.sv
// Victim way selection: lowest invalid way, else the
// round-robin pointer held by the parent.
module icache_victim_picker
    import set_assoc_icache_fetch_pkg::*;
#(
    parameter int unsigned WAY_COUNT = 2,
    parameter int unsigned WIW       = way_idx_width(WAY_COUNT)
) (
    input  logic [WAY_COUNT-1:0] set_valid,
    input  logic [WIW-1:0]       ptr,
    output logic [WIW-1:0]       victim,
    output logic                 set_full
);

    assign set_full = &set_valid;

    always_comb begin
        victim = ptr;
        for (int w = WAY_COUNT - 1; w >= 0; w--) begin
            if (!set_valid[w]) begin
                victim = WIW'(w);
            end
        end
    end

endmodule

// File: rtl/set_assoc_icache_fetch.sv
// N-way set-associative instruction cache for the fetch stage:
// one lookup per cycle, blocking refill, full-cache invalidate walk.
module set_assoc_icache_fetch
    import set_assoc_icache_fetch_pkg::*;
#(
    parameter  int unsigned WAY_COUNT   = 2,
    parameter  int unsigned INDEX_WIDTH = 6,
    parameter  int unsigned LINE_WIDTH  = 128,
    parameter  int unsigned PADDR_WIDTH = 34,
    localparam int unsigned INDEX_LSB   = $clog2(LINE_WIDTH / 8)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         reqValid,
    input  logic [PADDR_WIDTH-1:0]       reqAddr,
    output logic                         reqReady,
    input  logic                         flush,
    output logic                         respValid,
    output logic [PADDR_WIDTH-1:0]       respAddr,
    output logic [LINE_WIDTH-1:0]        respLine,
    input  logic                         invalidateReq,
    output logic                         invalidateDone,
    output logic [PADDR_WIDTH-INDEX_LSB-1:0] memAddr,
    output logic                         memReadReq,
    input  logic                         memReadGrant,
    input  logic [LINE_WIDTH-1:0]        memReadValue
);

    localparam int unsigned TAG_WIDTH =
        PADDR_WIDTH - INDEX_LSB - INDEX_WIDTH;
    localparam int unsigned SETS = 2 ** INDEX_WIDTH;
    localparam int unsigned WIW  = way_idx_width(WAY_COUNT);

    typedef logic [INDEX_WIDTH-1:0] index_t;
    typedef logic [TAG_WIDTH-1:0]   tag_t;
    typedef logic [WIW-1:0]         way_idx_t;

    icache_state_e state_q, state_d;
    logic pending_q, pending_d;
    logic drop_q, drop_d;
    logic relook_q, relook_d;
    logic done_q, done_d;
    logic lk_valid_q, lk_valid_d;
    logic [PADDR_WIDTH-1:0] lk_addr_q, lk_addr_d;
    index_t inv_cnt_q, inv_cnt_d;
    way_idx_t ptr_q, ptr_d;

    index_t lk_idx, rd_idx;
    tag_t lk_tag;
    logic [WAY_COUNT-1:0] hit, set_valid;
    logic [LINE_WIDTH-1:0] way_line [WAY_COUNT];
    way_idx_t victim;
    logic set_full, fill, accept, any_hit, miss;

    assign lk_idx  = lk_addr_q[INDEX_LSB +: INDEX_WIDTH];
    assign lk_tag  = lk_addr_q[PADDR_WIDTH-1 -: TAG_WIDTH];
    assign any_hit = |hit;
    assign miss    = lk_valid_q && !any_hit && !flush
                  && (state_q == ST_DEFAULT);

    assign respValid = lk_valid_q && any_hit && !flush && !rst;
    assign respAddr  = lk_addr_q;
    assign reqReady  = (state_q == ST_DEFAULT) && !pending_q
                    && !invalidateReq && !relook_q && !miss;
    assign accept    = reqValid && reqReady;
    assign rd_idx    = accept ? reqAddr[INDEX_LSB +: INDEX_WIDTH]
                              : lk_idx;

    // The held lookup address doubles as the refill address.
    assign fill       = (state_q == ST_REFILL) && memReadGrant && !rst;
    assign memReadReq = (state_q == ST_REFILL) && !rst;
    assign memAddr    = lk_addr_q[PADDR_WIDTH-1:INDEX_LSB];
    assign invalidateDone = done_q;

    icache_victim_picker #(
        .WAY_COUNT(WAY_COUNT),
        .WIW      (WIW)
    ) u_victim (
        .set_valid(set_valid),
        .ptr      (ptr_q),
        .victim   (victim),
        .set_full (set_full)
    );

    for (genvar w = 0; w < WAY_COUNT; w++) begin : g_way
        logic [SETS-1:0] valid_q;
        tag_t tag_mem [SETS];
        logic [LINE_WIDTH-1:0] data_mem [SETS];
        logic rd_valid_q;
        tag_t rd_tag_q;
        logic [LINE_WIDTH-1:0] rd_data_q;
        logic we;

        assign we = fill && (victim == way_idx_t'(w));

        always_ff @(posedge clk) begin
            if (rst) begin
                valid_q    <= '0;
                rd_valid_q <= 1'b0;
            end else begin
                if (state_q == ST_INVALIDATE) begin
                    valid_q[inv_cnt_q] <= 1'b0;
                end else if (we) begin
                    valid_q[lk_idx] <= 1'b1;
                end
                rd_valid_q <= valid_q[rd_idx];
            end
        end

        always_ff @(posedge clk) begin
            if (we) begin
                tag_mem[lk_idx]  <= lk_tag;
                data_mem[lk_idx] <= memReadValue;
            end
            rd_tag_q  <= tag_mem[rd_idx];
            rd_data_q <= data_mem[rd_idx];
        end

        assign set_valid[w] = valid_q[lk_idx];
        assign hit[w]       = rd_valid_q && (rd_tag_q == lk_tag);
        assign way_line[w]  = hit[w] ? rd_data_q : '0;
    end

    always_comb begin
        respLine = '0;
        for (int w = 0; w < WAY_COUNT; w++) begin
            respLine = respLine | way_line[w];
        end
    end

    always_comb begin
        state_d    = state_q;
        pending_d  = pending_q | invalidateReq;
        drop_d     = drop_q;
        relook_d   = 1'b0;
        done_d     = 1'b0;
        lk_valid_d = relook_q;
        lk_addr_d  = lk_addr_q;
        inv_cnt_d  = inv_cnt_q;
        ptr_d      = ptr_q;
        if (accept) begin
            lk_valid_d = 1'b1;
            lk_addr_d  = reqAddr;
        end
        unique case (state_q)
            ST_DEFAULT: begin
                if (miss) begin
                    state_d = ST_REFILL;
                    drop_d  = 1'b0;
                end else if (pending_q && !relook_q) begin
                    state_d   = ST_INVALIDATE;
                    inv_cnt_d = '0;
                    pending_d = invalidateReq;
                end
            end
            ST_REFILL: begin
                if (flush) begin
                    drop_d = 1'b1;
                end
                if (memReadGrant) begin
                    state_d  = ST_DEFAULT;
                    relook_d = !(drop_q || flush);
                    if (set_full) begin
                        ptr_d = (ptr_q == way_idx_t'(WAY_COUNT - 1))
                              ? '0 : ptr_q + 1'b1;
                    end
                end
            end
            ST_INVALIDATE: begin
                inv_cnt_d = inv_cnt_q + 1'b1;
                if (&inv_cnt_q) begin
                    state_d = ST_DEFAULT;
                    done_d  = 1'b1;
                end
            end
            default: state_d = ST_DEFAULT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_DEFAULT;
            pending_q  <= 1'b0;
            drop_q     <= 1'b0;
            relook_q   <= 1'b0;
            done_q     <= 1'b0;
            lk_valid_q <= 1'b0;
            lk_addr_q  <= '0;
            inv_cnt_q  <= '0;
            ptr_q      <= '0;
        end else begin
            state_q    <= state_d;
            pending_q  <= pending_d;
            drop_q     <= drop_d;
            relook_q   <= relook_d;
            done_q     <= done_d;
            lk_valid_q <= lk_valid_d;
            lk_addr_q  <= lk_addr_d;
            inv_cnt_q  <= inv_cnt_d;
            ptr_q      <= ptr_d;
        end
    end

    a_onehot_hit: assert property (
        @(posedge clk) disable iff (rst)
        lk_valid_q |-> $onehot0(hit)
    );

endmodule

// File: tb/tb_set_assoc_icache_fetch.sv
// Directed bench for set_assoc_icache_fetch with a response
// scoreboard fed at request time and drained by a monitor.
module tb_set_assoc_icache_fetch;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic reqValid = 1'b0;
    logic [33:0] reqAddr = '0;
    logic flush = 1'b0;
    logic invalidateReq = 1'b0;
    logic memReadGrant = 1'b0;
    logic [127:0] memReadValue = '0;
    logic reqReady, respValid, invalidateDone, memReadReq;
    logic [33:0] respAddr;
    logic [127:0] respLine;
    logic [29:0] memAddr;

    typedef struct packed {
        logic [33:0]  addr;
        logic [127:0] line;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int tests = 0;
    int fails = 0;
    int n;
    bit found;

    always #5 clk = ~clk;

    set_assoc_icache_fetch dut (
        .clk           (clk),
        .rst           (rst),
        .reqValid      (reqValid),
        .reqAddr       (reqAddr),
        .reqReady      (reqReady),
        .flush         (flush),
        .respValid     (respValid),
        .respAddr      (respAddr),
        .respLine      (respLine),
        .invalidateReq (invalidateReq),
        .invalidateDone(invalidateDone),
        .memAddr       (memAddr),
        .memReadReq    (memReadReq),
        .memReadGrant  (memReadGrant),
        .memReadValue  (memReadValue)
    );

    function automatic logic [127:0] line_for(input logic [33:0] a);
        logic [31:0] b;
        b = {2'b00, a[33:4]};
        return {b ^ 32'h1111_1111, b ^ 32'h2222_2222, ~b, b};
    endfunction

    task automatic chk1(input string tag, input logic obs,
                        input logic exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chkw(input string tag, input logic [127:0] obs,
                        input logic [127:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(negedge clk);
        reqValid      = 1'b0;
        flush         = 1'b0;
        invalidateReq = 1'b0;
        memReadGrant  = 1'b0;
    endtask

    task automatic req(input logic [33:0] a, input bit push);
        cyc();
        reqValid = 1'b1;
        reqAddr  = a;
        if (push) sb.push_back('{addr: a, line: line_for(a)});
        #1 chk1("req_ready", reqReady, 1'b1);
    endtask

    task automatic hit(input logic [33:0] a);
        req(a, 1'b1);
        cyc();
        #1 chk1("hit_t1", respValid, 1'b1);
    endtask

    task automatic serve(input logic [33:0] a);
        cyc();
        #1 chk1("memreq_on", memReadReq, 1'b1);
        chkw("mem_addr", 128'(memAddr), 128'(a[33:4]));
        cyc();
        #1 chk1("memreq_held", memReadReq, 1'b1);
        cyc();
        memReadGrant = 1'b1;
        memReadValue = line_for(a);
        #1 chk1("memreq_grant", memReadReq, 1'b1);
        cyc();
        #1 chk1("g1_noresp", respValid, 1'b0);
        chk1("g1_notready", reqReady, 1'b0);
        cyc();
        #1 chk1("g2_resp", respValid, 1'b1);
        chk1("g2_ready", reqReady, 1'b1);
    endtask

    task automatic miss_fill(input logic [33:0] a);
        req(a, 1'b1);
        cyc();
        #1 chk1("miss_noresp", respValid, 1'b0);
        chk1("miss_notready", reqReady, 1'b0);
        serve(a);
    endtask

    always begin
        @(negedge clk);
        #2;
        if (!rst && respValid) begin
            if (sb.size() == 0) begin
                chk1("sb_unexpected", respValid, 1'b0);
            end else begin
                mon_e = sb.pop_front();
                chkw("sb_addr", 128'(respAddr), 128'(mon_e.addr));
                chkw("sb_line", respLine, mon_e.line);
            end
        end
    end

    initial begin
        repeat (3) cyc();
        rst = 1'b0;
        #1 chk1("rst_resp", respValid, 1'b0);
        chk1("rst_done", invalidateDone, 1'b0);
        chk1("rst_memreq", memReadReq, 1'b0);
        chk1("rst_ready", reqReady, 1'b1);

        // Conflict: four lines in set 0 of a 2-way cache.
        miss_fill(34'h0_0000);
        miss_fill(34'h0_4000);
        miss_fill(34'h0_8000);
        hit(34'h0_4000);
        miss_fill(34'h0_C000);
        hit(34'h0_8000);
        miss_fill(34'h0_4000);
        hit(34'h0_C000);

        // Invalidate wins over a same-cycle request.
        cyc();
        invalidateReq = 1'b1;
        reqValid      = 1'b1;
        reqAddr       = 34'h0_1000;
        #1 chk1("inv_same_rdy", reqReady, 1'b0);
        n = 0;
        found = 1'b0;
        for (int i = 1; i <= 200 && !found; i++) begin
            cyc();
            #1;
            if (i == 1) chk1("inv_pend_rdy", reqReady, 1'b0);
            if (invalidateDone) begin
                found = 1'b1;
                n = i;
            end
        end
        chkw("inv_done_cycle", 128'(n), 128'(66));
        cyc();
        #1 chk1("inv_done_pulse", invalidateDone, 1'b0);
        chk1("inv_rdy_after", reqReady, 1'b1);
        miss_fill(34'h0_C000);

        // Reset in the middle of a refill of an invalidated line.
        req(34'h0_4000, 1'b0);
        cyc();
        #1 chk1("rst_miss", respValid, 1'b0);
        cyc();
        #1 chk1("rst_memreq_on", memReadReq, 1'b1);
        cyc();
        rst = 1'b1;
        memReadGrant = 1'b1;
        memReadValue = line_for(34'h0_4000);
        #1 chk1("rst_memreq_drop", memReadReq, 1'b0);
        cyc();
        rst = 1'b0;
        #1 chk1("post_rst_memreq", memReadReq, 1'b0);
        chk1("post_rst_ready", reqReady, 1'b1);

        // Cold miss after reset, then streaming hits.
        miss_fill(34'h0_1000);
        miss_fill(34'h0_1010);
        miss_fill(34'h0_1020);
        req(34'h0_1000, 1'b1);
        req(34'h0_1010, 1'b1);
        chk1("stream_a", respValid, 1'b1);
        req(34'h0_1020, 1'b1);
        chk1("stream_b", respValid, 1'b1);
        cyc();
        #1 chk1("stream_c", respValid, 1'b1);

        // Flush in Default with a same-cycle request.
        req(34'h0_1000, 1'b0);
        cyc();
        flush    = 1'b1;
        reqValid = 1'b1;
        reqAddr  = 34'h0_1010;
        sb.push_back('{addr: 34'h0_1010, line: line_for(34'h0_1010)});
        #1 chk1("flush_noresp", respValid, 1'b0);
        chk1("flush_ready", reqReady, 1'b1);
        cyc();
        #1 chk1("flush_new_resp", respValid, 1'b1);

        // Flush during refill: line written, no response.
        req(34'h0_2000, 1'b0);
        cyc();
        #1 chk1("fr_miss", respValid, 1'b0);
        cyc();
        flush = 1'b1;
        #1 chk1("fr_memreq", memReadReq, 1'b1);
        cyc();
        memReadGrant = 1'b1;
        memReadValue = line_for(34'h0_2000);
        cyc();
        #1 chk1("fr_noresp1", respValid, 1'b0);
        chk1("fr_ready", reqReady, 1'b1);
        cyc();
        #1 chk1("fr_noresp2", respValid, 1'b0);
        hit(34'h0_2000);

        repeat (3) cyc();
        #3 chkw("sb_empty", 128'(sb.size()), 128'(0));
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
